fcw_sweep: RTL and testbench
============================

Name: fcw_sweep

Overview:
- Upstream control stage for the NCO: generates the frequency control word (`fcw`) that drives the phase accumulator.
- Produces a stepped linear frequency sweep (chirp) from a start word to a stop word.
- Each frequency is held for a programmable dwell time.
- Three modes: single-shot, repeating sawtooth, continuous triangle. Configuration is latched at `start`, so the NCO sees a clean, glitch-free `fcw` sequence.

Parameters:
- N, 16, width of the frequency control words (matches the NCO `fcw` width).
- D, 16, width of the dwell counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored while `busy`.
- abort  input  1  stops any sweep; priority over `start`.
- f_start  input  N  first frequency word; latched on accepted `start`.
- f_stop  input  N  end frequency word; latched on accepted `start`.
- f_step  input  N  increment per step; latched on accepted `start`.
- dwell  input  D  hold each word for dwell+1 cycles; latched on accepted `start`.
- mode  input  2  0 = single, 1 = repeat sawtooth, 2 = triangle, 3 = single. Latched on accepted `start`.
- fcw  output  N  registered frequency word to the NCO.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a single-mode sweep completes.

Behaviour:
- **Reset** (sampled high at a clk edge, any state): state = IDLE, `fcw` = 0, `busy` = 0, `done` = 0, dwell counter = 0, latched config cleared. A reset mid-sweep behaves identically.
- **States:** IDLE, UP, DOWN.
- **IDLE:**
  - `start`=1 and `abort`=0 at edge E → after E: `fcw` = `f_start`, `busy` = 1, dwell counter = `dwell`, state UP.
  - Otherwise `fcw` holds its last value.
- **UP / DOWN dwell:** dwell counter decrements each cycle. The current `fcw` is held for exactly dwell+1 cycles. The word changes on the edge at which the counter reads 0 (expiry); the counter reloads to latched `dwell` at that edge.
- **UP expiry, `fcw` < `f_stop`:**
  - Sum = `fcw` + `f_step`, computed N+1 bits wide.
  - If sum > `f_stop` (including carry out), `fcw` = `f_stop` (clamp); else `fcw` = sum[N-1:0].
- **UP expiry, `fcw` >= `f_stop`:**
  - single: state IDLE, `busy` = 0, `done` = 1 for one cycle, `fcw` holds its value.
  - repeat: `fcw` = `f_start`, stay UP.
  - triangle: state DOWN, `fcw` = the DOWN next-value rule below. The stop word is held for only one dwell period.
- **DOWN expiry, `fcw` > `f_start`:**
  - Diff = `fcw` − `f_step`, computed N+1 bits wide.
  - If the diff borrows or diff < `f_start`, `fcw` = `f_start`; else `fcw` = diff.
- **DOWN expiry, `fcw` <= `f_start`:** state UP, `fcw` = the UP next-value rule (clamped increment).
- **Degenerate cases:**
  - `f_stop` <= `f_start`: `f_start` is held one dwell, then the end-of-sweep action for the mode applies. In triangle mode with `f_stop` == `f_start`, `fcw` stays constant until `abort`.
  - `f_step` = 0 with `f_start` < `f_stop`: `fcw` holds `f_start` indefinitely and `busy` stays 1 until `abort`/`reset`.
- **abort=1 at any edge:** next cycle state IDLE, `fcw` = 0, `busy` = 0, `done` = 0. A `start` in the same cycle is ignored.
- **start while busy:** ignored; config inputs may change freely without effect.
- **done:**
  - Asserted in the same cycle that `busy` first reads 0.
  - A new `start` may be accepted in that cycle; its `f_start` appears on the following cycle.
- **Timing:** all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- **Single:** N=16, f_start=100, f_stop=130, f_step=10, dwell=1, mode=0, start pulse.
  - Required `fcw`: 100,100,110,110,120,120,130,130.
  - Then `done`=1 for one cycle, `busy`=0, `fcw` holds 130.
- **Clamp and overflow:**
  - f_start=100, f_stop=125, f_step=10, dwell=0 → `fcw` 100,110,120,125, then done.
  - f_start=65530, f_stop=65535, f_step=10 → `fcw` 65530,65535, then done; no wrap to 4.
- **Repeat:** f_start=0, f_stop=20, f_step=10, dwell=0, mode=1 → `fcw` 0,10,20,0,10,20,… with `busy` steady 1 and `done` never asserted.
- **Triangle:** same config, mode=2 → `fcw` 0,10,20,10,0,10,20,10,0.
- **Abort and start:**
  - Abort mid-sweep with `start` asserted in the same cycle → next cycle `fcw`=0, `busy`=0, no `done`.
  - A later `start` restarts from `f_start`.
  - A `start` pulse during `busy` leaves the sequence unchanged.
- **Reset mid-sweep:** reset during the UP state of a triangle sweep → next cycle `fcw`=0, `busy`=0, `done`=0, IDLE; the block ignores stale config until the next `start`.

Source files
------------

// File: rtl/fcw_sweep.sv
// fcw_sweep: stepped linear frequency sweep generator feeding an NCO.
// A sweep runs from a start word to a stop word in fixed increments. Each word
// is held for dwell+1 cycles. Three sweep shapes are available: single-shot,
// repeating sawtooth and continuous triangle. All configuration is captured
// when a sweep is accepted, so the inputs may change freely during a sweep.
//
// Handshake: start is a one-cycle request that is honoured only while busy is
// low and abort is low. There is no back-pressure. abort takes priority over
// everything except reset. done pulses for one cycle in the first cycle that
// busy reads low after a single-shot sweep. A new start may be accepted in
// that same cycle.
module fcw_sweep #(
  parameter int N = 16,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] f_start,
  input  logic [N-1:0] f_stop,
  input  logic [N-1:0] f_step,
  input  logic [D-1:0] dwell,
  input  logic [1:0]   mode,
  output logic [N-1:0] fcw,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  state_t       state_q, state_d;
  logic [N-1:0] fcw_q, fcw_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  // Configuration captured on an accepted start.
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] stop_q, stop_d;
  logic [N-1:0] step_q, step_d;
  logic [D-1:0] dwell_q, dwell_d;
  logic [1:0]   mode_q, mode_d;

  // Candidate words for the next step in each direction.
  logic [N:0]   sum_w;
  logic [N:0]   diff_w;
  logic [N-1:0] up_next;
  logic [N-1:0] down_next;
  logic         expired;

  // Clamped increment and decrement, one extra bit to catch carry and borrow.
  always_comb begin
    sum_w     = {1'b0, fcw_q} + {1'b0, step_q};
    diff_w    = {1'b0, fcw_q} - {1'b0, step_q};
    up_next   = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[N-1:0];
    down_next = (diff_w[N] || (diff_w[N-1:0] < start_q)) ? start_q : diff_w[N-1:0];
    expired   = (cnt_q == '0);
  end

  // Next-state logic: idle/accept, dwell countdown, end-of-leg decisions.
  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;

    if (abort) begin
      state_d = S_IDLE;
      fcw_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_d = f_start;
            stop_d  = f_stop;
            step_d  = f_step;
            dwell_d = dwell;
            mode_d  = mode;
            fcw_d   = f_start;
            cnt_d   = dwell;
            state_d = S_UP;
          end
        end

        S_UP: begin
          if (!expired) begin
            cnt_d = cnt_q - {{(D-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = dwell_q;
            if (fcw_q < stop_q) begin
              fcw_d = up_next;
            end else begin
              case (mode_q)
                MODE_REPEAT: begin
                  fcw_d = start_q;
                end
                MODE_TRIANGLE: begin
                  // The stop word gets a single dwell; turn around immediately.
                  state_d = S_DOWN;
                  fcw_d   = down_next;
                end
                default: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end
          end
        end

        S_DOWN: begin
          if (!expired) begin
            cnt_d = cnt_q - {{(D-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = dwell_q;
            if (fcw_q > start_q) begin
              fcw_d = down_next;
            end else begin
              // The start word is the bottom of the triangle; head back up.
              state_d = S_UP;
              fcw_d   = up_next;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          fcw_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fcw_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  assign fcw         = fcw_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fcw_sweep.sv
// tb_fcw_sweep: directed and randomized sweeps checked against a word-level
// model of the sweep sequence.
module tb_fcw_sweep;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic [1:0]  mode;
  logic [15:0] fcw;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  fcw_sweep #(.N(16), .D(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .mode        (mode),
    .fcw         (fcw),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_fcw, input logic e_busy, input logic e_done);
    chk({tag, ".fcw"},  {16'd0, fcw},  {16'd0, e_fcw});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  // Word-level model: next word of the sweep with plain integer arithmetic.
  function automatic logic [15:0] inc_clamp(input logic [15:0] w, input logic [15:0] st, input logic [15:0] fe);
    int s;
    s = int'(w) + int'(st);
    if (s > int'(fe)) return fe;
    return 16'(s);
  endfunction

  function automatic logic [15:0] dec_clamp(input logic [15:0] w, input logic [15:0] st, input logic [15:0] fs);
    int d;
    d = int'(w) - int'(st);
    if (d < int'(fs)) return fs;
    return 16'(d);
  endfunction

  task automatic launch(input logic [15:0] fs, input logic [15:0] fe, input logic [15:0] st,
                        input logic [15:0] dw, input logic [1:0] md);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md;
    start = 1'b1;
    step();
    start = 1'b0;
    // Scramble the config inputs: the running sweep must not see them.
    f_start = 16'($urandom); f_stop = 16'($urandom);
    f_step  = 16'($urandom); dwell  = 16'($urandom_range(0, 5));
    mode    = 2'($urandom);
  endtask

  // Runs a whole sweep. Single-shot modes run to done; periodic modes are
  // checked for ncyc cycles then aborted with a simultaneous start.
  // poke_at >= 0 pulses start at that cycle of the sweep (must be ignored).
  task automatic run_sweep(input string tag, input logic [15:0] fs, input logic [15:0] fe,
                           input logic [15:0] st, input logic [15:0] dw, input logic [1:0] md,
                           input int ncyc, input int poke_at);
    logic [15:0] w;
    logic [15:0] last_w;
    logic [15:0] e;
    logic        going_up;
    logic        single;
    int          n;
    exp_q.delete();
    single   = (md == 2'd0) || (md == 2'd3);
    w        = fs;
    going_up = 1'b1;
    if (single) begin
      for (int k = 0; k < 2000; k++) begin
        repeat (int'(dw) + 1) exp_q.push_back(w);
        if (w >= fe) break;
        w = inc_clamp(w, st, fe);
      end
    end else begin
      while (exp_q.size() < ncyc) begin
        repeat (int'(dw) + 1) exp_q.push_back(w);
        if (md == 2'd1) begin
          w = (w < fe) ? inc_clamp(w, st, fe) : fs;
        end else if (going_up) begin
          if (w < fe) w = inc_clamp(w, st, fe);
          else begin going_up = 1'b0; w = dec_clamp(w, st, fs); end
        end else begin
          if (w > fs) w = dec_clamp(w, st, fs);
          else begin going_up = 1'b1; w = inc_clamp(w, st, fe); end
        end
      end
      while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    end

    launch(fs, fe, st, dw, md);
    n = 0;
    last_w = fs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_w = e;
      chk_out(tag, e, 1'b1, 1'b0);
      if (n == poke_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
    end
    if (single) begin
      chk_out({tag, ".end"}, last_w, 1'b0, 1'b1);
      step();
      chk_out({tag, ".after"}, last_w, 1'b0, 1'b0);
    end else begin
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk_out({tag, ".abort"}, 16'd0, 1'b0, 1'b0);
      step();
      chk_out({tag, ".abort2"}, 16'd0, 1'b0, 1'b0);
    end
  endtask

  // Directed and random steps
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = 16'd0; f_stop = 16'd0; f_step = 16'd0; dwell = 16'd0; mode = 2'd0;
    step();
    step();
    chk_out("reset", 16'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("idle", 16'd0, 1'b0, 1'b0);

    // Single sweep 100,100,110,110,120,120,130,130 then done
    run_sweep("single", 16'd100, 16'd130, 16'd10, 16'd1, 2'd0, 0, -1);
    // Clamp at the stop word; mode 3 behaves as single
    run_sweep("clamp", 16'd100, 16'd125, 16'd10, 16'd0, 2'd3, 0, -1);
    // Increment carries out of 16 bits: clamp, no wrap
    run_sweep("ovf", 16'd65530, 16'd65535, 16'd10, 16'd0, 2'd0, 0, -1);
    // Repeat sawtooth 0,10,20,0,...
    run_sweep("repeat", 16'd0, 16'd20, 16'd10, 16'd0, 2'd1, 12, -1);
    // Triangle 0,10,20,10,0,10,20,10,0
    run_sweep("tri", 16'd0, 16'd20, 16'd10, 16'd0, 2'd2, 9, -1);
    // Restart after abort, with a start pulse during busy that must be ignored
    run_sweep("poke", 16'd100, 16'd130, 16'd10, 16'd1, 2'd0, 0, 3);
    // Degenerate: stop below start, single-shot holds start for one dwell
    run_sweep("stop_lt", 16'd200, 16'd100, 16'd5, 16'd2, 2'd0, 0, -1);
    // Degenerate: triangle with stop == start stays constant
    run_sweep("tri_eq", 16'd500, 16'd500, 16'd7, 16'd1, 2'd2, 10, -1);
    // Degenerate: zero step holds the start word while busy
    run_sweep("step0", 16'd50, 16'd60, 16'd0, 16'd0, 2'd0 + 2'd1, 10, -1);

    // Zero step in single mode: never finishes, abort ends it
    launch(16'd50, 16'd60, 16'd0, 16'd0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      chk_out("step0s", 16'd50, 1'b1, 1'b0);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("step0s.abort", 16'd0, 1'b0, 1'b0);

    // Start accepted in the done cycle: new f_start on the next cycle
    launch(16'd100, 16'd125, 16'd10, 16'd0, 2'd0);
    repeat (4) step();
    chk_out("chain.done", 16'd125, 1'b0, 1'b1);
    f_start = 16'd7; f_stop = 16'd7; f_step = 16'd1; dwell = 16'd0; mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("chain.new", 16'd7, 1'b1, 1'b0);
    step();
    chk_out("chain.done2", 16'd7, 1'b0, 1'b1);
    step();

    // Reset during the up leg of a triangle sweep
    launch(16'd0, 16'd20, 16'd10, 16'd0, 2'd2);
    chk_out("rst.pre", 16'd0, 1'b1, 1'b0);
    step();
    chk_out("rst.pre2", 16'd10, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("rst.post", 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("rst.idle", 16'd0, 1'b0, 1'b0);
    end

    // Randomized sweeps
    for (int r = 0; r < 10; r++) begin
      logic [15:0] fs, fe, st, dw;
      logic [1:0]  md;
      int span;
      span = $urandom_range(0, 300);
      fs   = 16'($urandom_range(0, 60000));
      fe   = 16'(int'(fs) + span);
      st   = 16'($urandom_range(1, span / 3 + 2));
      dw   = 16'($urandom_range(0, 3));
      md   = 2'($urandom_range(0, 3));
      run_sweep("rand", fs, fe, st, dw, md, 40, $urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
